// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel stream filter: pixel width default,
// gradient width derivation and the 3x3 kernel weights.
package sobel_pkg;

  localparam int unsigned PIX_W_DEF  = 8;
  // Headroom bits: weights 1+2+1 add two bits; the |Gx|+|Gy| sum adds one more.
  localparam int unsigned GRAD_EXTRA = 3;

  // Sobel kernel weights along the smoothing axis.
  localparam int unsigned K_EDGE     = 1;
  localparam int unsigned K_CENTRE   = 2;

  // Unsigned gradient width for a given pixel width.
  function automatic int unsigned grad_w(input int unsigned pix_w);
    return pix_w + GRAD_EXTRA;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of storage. The read is asynchronous at the write address, so the
// caller sees the previous content of a location in the cycle that it overwrites it.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = PIX_W_DEF,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rd_data_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Line storage; not reset, since stale content is masked by window gating.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rd_data_c = mem[addr];

endmodule

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter over a raster-order grayscale pixel stream.
// Two pipeline stages: gradients, then magnitude/threshold.
module sobel_stream_filter
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned PIX_W  = PIX_W_DEF,
  localparam int unsigned GRAD_W = grad_w(PIX_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic [GRAD_W-1:0] threshold,
  output logic              out_valid,
  output logic [PIX_W-1:0]  mag_out,
  output logic              edge_out,
  output logic              frame_done
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned SW = GRAD_W + 1;
  localparam logic [SW-1:0] MAG_MAX = {{(SW - PIX_W){1'b0}}, {PIX_W{1'b1}}};

  logic [XW-1:0] col_q;
  logic [YW-1:0] row_q;
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic          accept;
  logic          in_window;
  logic          at_last;

  // Position of the pixel on the input this cycle; start-of-frame overrides counters.
  always_comb begin
    accept    = in_valid;
    pos_x     = in_sof ? '0 : col_q;
    pos_y     = in_sof ? '0 : row_q;
    in_window = (pos_x >= XW'(2)) && (pos_y >= YW'(2));
    at_last   = (pos_x == XW'(IMG_W - 1)) && (pos_y == YW'(IMG_H - 1));
  end

  // Raster counters, advancing only on accepted pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (pos_x == XW'(IMG_W - 1)) begin
        col_q <= '0;
        row_q <= (pos_y == YW'(IMG_H - 1)) ? '0 : pos_y + YW'(1);
      end else begin
        col_q <= pos_x + XW'(1);
        row_q <= pos_y;
      end
    end
  end

  logic [PIX_W-1:0] row1_c;
  logic [PIX_W-1:0] row2_c;

  // Row y-1 buffer: takes the incoming pixel.
  sobel_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb_row1 (
    .clk       (clk),
    .we        (accept),
    .addr      (pos_x),
    .wdata     (pixel_in),
    .rd_data_c (row1_c)
  );

  // Row y-2 buffer: takes what row y-1 held at this column.
  sobel_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb_row2 (
    .clk       (clk),
    .we        (accept),
    .addr      (pos_x),
    .wdata     (row1_c),
    .rd_data_c (row2_c)
  );

  // Window columns x-1 (suffix 1) and x-2 (suffix 2); column x is live from the buffers.
  logic [PIX_W-1:0] top1_q, mid1_q, bot1_q;
  logic [PIX_W-1:0] top2_q, mid2_q, bot2_q;

  // Shift the window one column per accepted pixel.
  always_ff @(posedge clk) begin
    if (accept) begin
      top1_q <= row2_c;
      mid1_q <= row1_c;
      bot1_q <= pixel_in;
      top2_q <= top1_q;
      mid2_q <= mid1_q;
      bot2_q <= bot1_q;
    end
  end

  // 1-2-1 weighted sum along one window edge.
  function automatic logic [GRAD_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
    return GRAD_W'(a) * GRAD_W'(K_EDGE) + GRAD_W'(b) * GRAD_W'(K_CENTRE) +
           GRAD_W'(c) * GRAD_W'(K_EDGE);
  endfunction

  logic [GRAD_W-1:0]    right_c, left_c, top_c, bottom_c;
  logic signed [SW-1:0] gx_c, gy_c;

  // Horizontal and vertical gradients of the current window.
  always_comb begin
    right_c  = wsum(row2_c, row1_c, pixel_in);
    left_c   = wsum(top2_q, mid2_q, bot2_q);
    top_c    = wsum(top2_q, top1_q, row2_c);
    bottom_c = wsum(bot2_q, bot1_q, pixel_in);
    gx_c     = $signed({1'b0, right_c}) - $signed({1'b0, left_c});
    gy_c     = $signed({1'b0, bottom_c}) - $signed({1'b0, top_c});
  end

  logic signed [SW-1:0] gx_q, gy_q;
  logic                 s1_valid_q;
  logic                 s1_last_q;

  // Stage 1 valid tags; cleared by reset so in-flight results are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= accept && in_window;
      s1_last_q  <= accept && in_window && at_last;
    end
  end

  // Stage 1 gradient registers.
  always_ff @(posedge clk) begin
    if (accept && in_window) begin
      gx_q <= gx_c;
      gy_q <= gy_c;
    end
  end

  logic [SW-1:0] abs_x_c, abs_y_c, sum_c;

  // L1 magnitude of the registered gradients.
  always_comb begin
    abs_x_c = gx_q[SW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    abs_y_c = gy_q[SW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    sum_c   = abs_x_c + abs_y_c;
  end

  // Stage 2: saturated magnitude and edge flag; data holds while no result is due.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      mag_out    <= '0;
      edge_out   <= 1'b0;
    end else begin
      out_valid  <= s1_valid_q;
      frame_done <= s1_last_q;
      if (s1_valid_q) begin
        mag_out  <= (sum_c > MAG_MAX) ? {PIX_W{1'b1}} : sum_c[PIX_W-1:0];
        edge_out <= sum_c > {1'b0, threshold};
      end
    end
  end

endmodule
